// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among byte producers
module uart_tx_arbiter #(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    NUM_REQ        = 4,
    parameter int                    ID_W           = $clog2(NUM_REQ),
    parameter bit                    HEADER_EN      = 1'b1,
    parameter logic [DATA_WIDTH-1:0] HEADER_BASE    = DATA_WIDTH'(8'hA0),
    parameter int                    TIMEOUT_CYCLES = 200000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_in,
    input  logic                          tx_dv,
    output logic [ID_W-1:0]               grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    // Watchdog counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout
    // keeps a one-bit counter that never advances.
    localparam bit              WDOG_EN  = (TIMEOUT_CYCLES > 0);
    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_HDR_START = 3'd1,
        S_HDR_WAIT  = 3'd2,
        S_DAT_START = 3'd3,
        S_DAT_WAIT  = 3'd4
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [ID_W-1:0]         last_grant;
    logic [ID_W-1:0]         pick;
    logic [ID_W-1:0]         cand;
    logic                    any_valid;
    logic [DATA_WIDTH-1:0]   pick_data;
    logic [DATA_WIDTH-1:0]   hdr_byte;
    logic [DATA_WIDTH-1:0]   data_reg;
    logic [CNT_W-1:0]        wait_cnt;
    logic                    in_wait;
    logic                    in_start;
    logic                    timeout_hit;
    logic                    grant_now;

    assign in_wait     = (state == S_HDR_WAIT) || (state == S_DAT_WAIT);
    assign in_start    = (state == S_HDR_START) || (state == S_DAT_START);
    assign timeout_hit = WDOG_EN && in_wait && (wait_cnt == CNT_LAST);
    assign grant_now   = (state == S_IDLE) && any_valid;
    assign hdr_byte    = HEADER_BASE | DATA_WIDTH'(pick);

    // Round-robin search: first valid requester after last_grant, wrapping.
    always_comb begin
        pick      = last_grant;
        cand      = '0;
        any_valid = 1'b0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (!any_valid && req_valid[cand]) begin
                any_valid = 1'b1;
                pick      = cand;
            end
        end
    end

    // Byte offered by the selected requester.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == ID_W'(i)) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state; tx_dv takes priority over a watchdog expiry in the same cycle.
    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE: begin
                if (any_valid) begin
                    next_state = HEADER_EN ? S_HDR_START : S_DAT_START;
                end
            end
            S_HDR_START: next_state = S_HDR_WAIT;
            S_DAT_START: next_state = S_DAT_WAIT;
            S_HDR_WAIT: begin
                if (tx_dv) begin
                    next_state = S_DAT_START;
                end else if (timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            S_DAT_WAIT: begin
                if (tx_dv || timeout_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // FSM decoded outputs; no acceptance is offered while the block is held in reset.
    always_comb begin
        busy        = (state != S_IDLE);
        timeout_err = timeout_hit && !tx_dv;
        req_ready   = '0;
        if (rst_n && grant_now) begin
            req_ready = NUM_REQ'(1) << pick;
        end
    end

    // Grant bookkeeping, captured byte and the registered transmitter interface.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start   <= 1'b0;
            tx_in      <= '0;
            data_reg   <= '0;
            grant_id   <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else begin
            tx_start <= (next_state == S_HDR_START) || (next_state == S_DAT_START);
            if (grant_now) begin
                data_reg   <= pick_data;
                last_grant <= pick;
                grant_id   <= pick;
                tx_in      <= HEADER_EN ? hdr_byte : pick_data;
            end else if ((state == S_HDR_WAIT) && (next_state == S_DAT_START)) begin
                tx_in <= data_reg;
            end
        end
    end

    // Frame watchdog: cleared while a start pulse is out, counts while waiting for tx_dv.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (in_start) begin
            wait_cnt <= '0;
        end else if (in_wait && WDOG_EN) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte producers using round-robin arbitration.
- Sits between the producers and the transmitter's tx_start/tx_in/tx_dv interface.
- Can optionally prefix each data byte with a header byte that identifies the source.
- Runs a watchdog on each frame so a stalled transmitter cannot lock up the arbiter.

Parameters:
- DATA_WIDTH, 8: width of each UART byte.
- NUM_REQ, 4: number of requesters. Legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of grant_id.
- HEADER_EN, 1: when 1, each granted byte is preceded by a header byte.
- HEADER_BASE, 8'hA0: header byte = HEADER_BASE | zero-extended requester id. Low ID_W bits of HEADER_BASE must be 0.
- TIMEOUT_CYCLES, 200000: maximum clk cycles to wait for tx_dv after a tx_start. 0 disables the watchdog.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- req_valid, input, NUM_REQ: per-requester byte-valid.
- req_data, input, NUM_REQ*DATA_WIDTH: requester i's byte is bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready, output, NUM_REQ: one-hot acceptance strobe.
- tx_start, output, 1: one-cycle start pulse to the transmitter.
- tx_in, output, DATA_WIDTH: byte to transmit.
- tx_dv, input, 1: one-cycle pulse from the transmitter when a frame (stop bit) completes.
- grant_id, output, ID_W: index of the current or most recent grant.
- busy, output, 1: high in every state except IDLE.
- timeout_err, output, 1: one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE; tx_start=0; tx_in=0; grant_id=0; timeout_err=0; req_ready=0; data register=0; last_grant=NUM_REQ-1, so requester 0 wins first.
- States: IDLE, HDR_START, HDR_WAIT, DAT_START, DAT_WAIT.

IDLE:
- If any req_valid, select the first set bit searching from last_grant+1, wrapping modulo NUM_REQ.
- req_ready[g] is asserted combinationally in that same cycle; all other bits stay 0.
- On that edge: req_data[g] latches into the data register, last_grant and grant_id take g, and state moves to HDR_START (HEADER_EN=1) or DAT_START (HEADER_EN=0).
- No req_valid: stay in IDLE.

HDR_START / DAT_START:
- Exactly one cycle.
- tx_start=1 (registered output).
- tx_in = header byte or data byte respectively.
- Next state HDR_WAIT / DAT_WAIT. The watchdog counter clears to 0.

HDR_WAIT / DAT_WAIT:
- tx_in holds stable; tx_start=0; the counter increments each cycle.
- tx_dv=1: HDR_WAIT -> DAT_START, DAT_WAIT -> IDLE.
- Counter reaches TIMEOUT_CYCLES-1 with tx_dv=0: timeout_err pulses for one cycle, state returns to IDLE, and the byte is dropped. last_grant still advances.
- tx_dv and timeout in the same cycle: tx_dv wins, no error.

Other rules:
- req_ready is never asserted outside IDLE. A requester holds req_valid and req_data until it sees req_ready.
- tx_dv in IDLE or a START state is ignored.
- Latency: req_valid rises at cycle 0 while IDLE, then tx_start=1 at cycle 1. A final tx_dv at cycle t puts the block in IDLE at t+1; the next tx_start is at t+2 at the earliest.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0.
- Reset mid-frame: all state is cleared immediately and the in-flight byte is lost. A tx_dv arriving after reset is ignored.
- grant_id holds its last value while in IDLE.

Test Plan:
- HEADER_EN=1, req_valid=4'b0100, req_data[2]=8'h55. Expect req_ready=4'b0100 for 1 cycle, tx_start with tx_in=8'hA2. Return tx_dv 10 cycles later, then expect tx_start with tx_in=8'h55. After a second tx_dv, busy=0.
- All four requesters valid continuously, bytes 8'h10..8'h13, tx_dv returned 5 cycles after each start. Expect data bytes in order 10,11,12,13,10, each preceded by headers A0..A3.
- HEADER_EN=0, requester 3 only, then requesters 0 and 3 both valid. Expect grant order 3,0,3. Expect tx_start one cycle after req_valid, with no header byte sent.
- TIMEOUT_CYCLES=20, tx_dv never returned. Expect timeout_err pulse 20 cycles after the header tx_start and no data byte sent. The next request is granted normally.
- tx_dv pulse in the same cycle the counter hits 19. Expect no timeout_err and normal progression to DAT_START.
- Assert rst_n=0 during DAT_WAIT. Expect all outputs 0 immediately. After release, a stray tx_dv is ignored and requester 0 wins the first grant.
